// File: rtl/mnist_hex_pio_arbiter.sv
// ---------------------------------------------------------------------------
// mnist_hex_pio_arbiter
//
// Purpose:
//   This block arbitrates writes from two requesters to the 16-bit hex-digit
//   PIO slave. Requester 0 is the CPU display path and requester 1 is the NN
//   inference result engine.
//
//   Each requester has a one-entry capture slot. Captured values are written
//   to the PIO over Avalon-MM, one write per cycle at most.
//
//   A dwell counter protects the current owner's value. The other requester
//   cannot overwrite it until DWELL_CYCLES have passed. The current owner can
//   update its own value at any time.
//
//   Round-robin arbitration applies only when both requesters are eligible
//   in the same cycle.
//
// Parameters:
//   DWELL_CYCLES : minimum cycles before the other requester may write.
//                  Legal range is 1 .. 2^CNT_W-1.
//   CNT_W        : width of the dwell counter.
//
// Ports:
//   clk            : clock
//   reset_n        : asynchronous, active-low reset
//   req0 / req1    : level request; data must be held stable until ack
//   data0 / data1  : 16-bit value to display
//   ack0 / ack1    : one-cycle pulse, value captured into the slot
//   avm_address    : Avalon-MM address (always 0)
//   avm_chipselect : high for exactly one cycle per write
//   avm_write_n    : low only together with chipselect
//   avm_writedata  : {16'b0, slot data} during a write, else 0
//   owner          : requester that performed the last write
//   owner_valid    : at least one write since reset
// ---------------------------------------------------------------------------
module mnist_hex_pio_arbiter #(
  parameter int DWELL_CYCLES = 50000000,
  parameter int CNT_W        = 26
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0,
  input  logic [15:0] data0,
  input  logic        req1,
  input  logic [15:0] data1,
  output logic        ack0,
  output logic        ack1,
  output logic [1:0]  avm_address,
  output logic        avm_chipselect,
  output logic        avm_write_n,
  output logic [31:0] avm_writedata,
  output logic        owner,
  output logic        owner_valid
);

  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES);

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t          state;
  state_t          next_state;
  logic            grant_idx;
  logic            next_grant;
  logic            last_grant;

  logic [15:0]     slot0;
  logic [15:0]     slot1;
  logic            pending0;
  logic            pending1;
  logic [CNT_W-1:0] cnt;

  logic            writing;
  logic            dwell_done;
  logic            elig0;
  logic            elig1;

  assign writing    = (state == WRITE);
  assign dwell_done = (cnt == '0);

  // A requester may write if it already owns the display, if nobody has
  // written yet, or if the previous owner's dwell time has run out.
  assign elig0 = pending0 && (!owner_valid || (owner == 1'b0) || dwell_done);
  assign elig1 = pending1 && (!owner_valid || (owner == 1'b1) || dwell_done);

  // State register. The granted index is captured together with the
  // IDLE->WRITE transition so that the WRITE cycle knows which slot to drive.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      grant_idx <= 1'b0;
    end else begin
      state     <= next_state;
      grant_idx <= next_grant;
    end
  end

  // Next-state and grant selection. On a tie, the requester that did not
  // receive the last grant wins.
  always_comb begin
    next_state = state;
    next_grant = grant_idx;
    case (state)
      IDLE: begin
        if (elig0 && elig1) begin
          next_grant = ~last_grant;
          next_state = WRITE;
        end else if (elig0) begin
          next_grant = 1'b0;
          next_state = WRITE;
        end else if (elig1) begin
          next_grant = 1'b1;
          next_state = WRITE;
        end
      end
      WRITE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Capture slots.
  // A slot accepts a new value only while it is empty. A slot being written
  // is still full during the WRITE cycle, so a request for it lands one edge
  // later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot0    <= 16'h0000;
      slot1    <= 16'h0000;
      pending0 <= 1'b0;
      pending1 <= 1'b0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;

      if (req0 && !pending0) begin
        slot0    <= data0;
        pending0 <= 1'b1;
        ack0     <= 1'b1;
      end else if (writing && (grant_idx == 1'b0)) begin
        pending0 <= 1'b0;
      end

      if (req1 && !pending1) begin
        slot1    <= data1;
        pending1 <= 1'b1;
        ack1     <= 1'b1;
      end else if (writing && (grant_idx == 1'b1)) begin
        pending1 <= 1'b0;
      end
    end
  end

  // Ownership bookkeeping and dwell counter.
  // Every write reloads the dwell counter. Outside a write, the counter
  // counts down and holds at zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner       <= 1'b0;
      owner_valid <= 1'b0;
      last_grant  <= 1'b1;
      cnt         <= '0;
    end else if (writing) begin
      owner       <= grant_idx;
      owner_valid <= 1'b1;
      last_grant  <= grant_idx;
      cnt         <= DWELL_LOAD;
    end else if (!dwell_done) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Bus outputs are decoded directly from the state register. Because of
  // this, an asynchronous reset removes chipselect at once.
  assign avm_address    = 2'b00;
  assign avm_chipselect = writing;
  assign avm_write_n    = ~writing;
  assign avm_writedata  = writing ? {16'h0000, (grant_idx ? slot1 : slot0)} : 32'h0000_0000;

endmodule

// File: tb/tb_mnist_hex_pio_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mnist_hex_pio_arbiter
//
// Purpose:
//   Directed testbench for mnist_hex_pio_arbiter. Expected values are
//   computed by hand.
//
// Instances:
//   dut      : DWELL_CYCLES = 8
//   dut_fast : DWELL_CYCLES = 1
//
//   Both instances share every input. Only the tie test checks dut_fast.
//
// Timing conventions:
//   Inputs are driven 1 time unit after the rising edge.
//   Outputs are sampled on the falling edge.
//   cyc numbers the cycle that begins at each rising edge.
// ---------------------------------------------------------------------------
module tb_mnist_hex_pio_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req0 = 1'b0;
  logic        req1 = 1'b0;
  logic [15:0] data0 = 16'h0000;
  logic [15:0] data1 = 16'h0000;

  // Outputs of the DWELL_CYCLES = 8 instance.
  logic        ack0, ack1, avm_chipselect, avm_write_n, owner, owner_valid;
  logic [1:0]  avm_address;
  logic [31:0] avm_writedata;

  // Outputs of the DWELL_CYCLES = 1 instance.
  logic        ack0_f, ack1_f, cs_f, write_n_f, owner_f, owner_valid_f;
  logic [1:0]  address_f;
  logic [31:0] writedata_f;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  logic prev_cs = 1'b0;

  mnist_hex_pio_arbiter #(.DWELL_CYCLES(8), .CNT_W(26)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .data0(data0), .req1(req1), .data1(data1),
    .ack0(ack0), .ack1(ack1),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect),
    .avm_write_n(avm_write_n), .avm_writedata(avm_writedata),
    .owner(owner), .owner_valid(owner_valid)
  );

  mnist_hex_pio_arbiter #(.DWELL_CYCLES(1), .CNT_W(4)) dut_fast (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .data0(data0), .req1(req1), .data1(data1),
    .ack0(ack0_f), .ack1(ack1_f),
    .avm_address(address_f), .avm_chipselect(cs_f),
    .avm_write_n(write_n_f), .avm_writedata(writedata_f),
    .owner(owner_f), .owner_valid(owner_valid_f)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Compare one observed value with its expected value.
  // Counts the comparison and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Drive the request inputs for the next cycle, just after the rising edge.
  task automatic applyStimulus(input logic r0, input logic [15:0] d0,
                               input logic r1, input logic [15:0] d1);
    @(posedge clk);
    #1;
    req0  = r0;
    data0 = d0;
    req1  = r1;
    data1 = d1;
  endtask

  // Hold reset for two edges, checking reset values, then release it
  // away from the clock edge.
  task automatic doReset();
    reset_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; data0 = 16'h0; data1 = 16'h0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ack0", {31'b0, ack0}, 32'd0);
    checkOutput("rst_cs", {31'b0, avm_chipselect}, 32'd0);
    checkOutput("rst_owner_valid", {31'b0, owner_valid}, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // Wait at most maxc falling edges for chipselect.
  // Returns the cycle number of the write, or -1 if none is seen.
  task automatic waitWrite(input int maxc, output int at_cyc, output logic [31:0] wdata);
    at_cyc = -1;
    wdata  = 32'h0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (avm_chipselect) begin
        at_cyc = cyc;
        wdata  = avm_writedata;
        break;
      end
    end
  endtask

  // Bus integrity: chipselect is never high in two consecutive cycles, and
  // the upper half of writedata is always zero during a write.
  always @(negedge clk) begin
    if (avm_chipselect) begin
      checkOutput("cs_gap", {31'b0, prev_cs}, 32'd0);
      checkOutput("wd_hi", {16'b0, avm_writedata[31:16]}, 32'd0);
    end
    prev_cs = avm_chipselect;
  end

  // Safety net in case a bounded wait is broken.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t;
    int w;
    int wc;
    int acks;
    int first_w;
    logic [31:0] wd;
    logic exp_f;

    // ---------------- reset values ----------------
    reset_n = 1'b0;
    #2;
    checkOutput("rst_async_cs", {31'b0, avm_chipselect}, 32'd0);
    checkOutput("rst_write_n", {31'b0, avm_write_n}, 32'd1);
    checkOutput("rst_writedata", avm_writedata, 32'd0);
    checkOutput("rst_address", {30'b0, avm_address}, 32'd0);
    checkOutput("rst_owner", {31'b0, owner}, 32'd0);
    checkOutput("rst_ack1", {31'b0, ack1}, 32'd0);
    doReset();

    // ---------------- basic write ----------------
    applyStimulus(1'b1, 16'h1234, 1'b0, 16'h0);
    t = cyc;
    @(negedge clk);
    checkOutput("basic_ack0_t0", {31'b0, ack0}, 32'd0);
    applyStimulus(1'b0, 16'h0, 1'b0, 16'h0);
    @(negedge clk);
    checkOutput("basic_ack0_t1", {31'b0, ack0}, 32'd1);
    checkOutput("basic_cs_t1", {31'b0, avm_chipselect}, 32'd0);
    applyStimulus(1'b0, 16'h0, 1'b0, 16'h0);
    @(negedge clk);
    checkOutput("basic_cs_t2", {31'b0, avm_chipselect}, 32'd1);
    checkOutput("basic_wn_t2", {31'b0, avm_write_n}, 32'd0);
    checkOutput("basic_wd_t2", avm_writedata, 32'h0000_1234);
    checkOutput("basic_addr_t2", {30'b0, avm_address}, 32'd0);
    checkOutput("basic_ack0_t2", {31'b0, ack0}, 32'd0);
    applyStimulus(1'b0, 16'h0, 1'b0, 16'h0);
    @(negedge clk);
    checkOutput("basic_cs_t3", {31'b0, avm_chipselect}, 32'd0);
    checkOutput("basic_owner", {31'b0, owner}, 32'd0);
    checkOutput("basic_owner_valid", {31'b0, owner_valid}, 32'd1);

    // ---------------- dwell blocks the other requester ----------------
    doReset();
    applyStimulus(1'b1, 16'h00AA, 1'b0, 16'h0);
    t = cyc;
    applyStimulus(1'b0, 16'h0, 1'b0, 16'h0);
    applyStimulus(1'b0, 16'h0, 1'b0, 16'h0);
    w = cyc;
    @(negedge clk);
    checkOutput("dwell_w_cs", {31'b0, avm_chipselect}, 32'd1);
    checkOutput("dwell_w_wd", avm_writedata, 32'h0000_00AA);
    applyStimulus(1'b0, 16'h0, 1'b1, 16'h00BB);
    applyStimulus(1'b0, 16'h0, 1'b0, 16'h0);
    @(negedge clk);
    checkOutput("dwell_ack1", {31'b0, ack1}, 32'd1);
    waitWrite(20, wc, wd);
    checkOutput("dwell_wr1_cycle", wc - w, 32'd10);
    checkOutput("dwell_wr1_data", wd, 32'h0000_00BB);
    applyStimulus(1'b0, 16'h0, 1'b0, 16'h0);
    @(negedge clk);
    checkOutput("dwell_owner", {31'b0, owner}, 32'd1);

    // ---------------- same owner bypasses dwell ----------------
    doReset();
    applyStimulus(1'b1, 16'h0001, 1'b0, 16'h0);
    t = cyc;
    applyStimulus(1'b1, 16'h0001, 1'b0, 16'h0);
    @(negedge clk);
    checkOutput("same_ack_a", {31'b0, ack0}, 32'd1);
    applyStimulus(1'b1, 16'h0002, 1'b0, 16'h0);
    @(negedge clk);
    checkOutput("same_w1_cs", {31'b0, avm_chipselect}, 32'd1);
    checkOutput("same_w1_wd", avm_writedata, 32'h0000_0001);
    applyStimulus(1'b1, 16'h0002, 1'b0, 16'h0);
    @(negedge clk);
    checkOutput("same_gap_cs", {31'b0, avm_chipselect}, 32'd0);
    applyStimulus(1'b0, 16'h0, 1'b0, 16'h0);
    @(negedge clk);
    checkOutput("same_ack_b", {31'b0, ack0}, 32'd1);
    waitWrite(10, wc, wd);
    checkOutput("same_w2_spacing", wc - (t + 2), 32'd3);
    checkOutput("same_w2_wd", wd, 32'h0000_0002);
    checkOutput("same_owner", {31'b0, owner}, 32'd0);

    // ---------------- simultaneous first requests ----------------
    doReset();
    applyStimulus(1'b1, 16'h0A0A, 1'b1, 16'h0B0B);
    t = cyc;
    applyStimulus(1'b0, 16'h0, 1'b0, 16'h0);
    @(negedge clk);
    checkOutput("sim_ack0", {31'b0, ack0}, 32'd1);
    checkOutput("sim_ack1", {31'b0, ack1}, 32'd1);
    for (int i = 2; i <= 5; i++) begin
      applyStimulus(1'b0, 16'h0, 1'b0, 16'h0);
      @(negedge clk);
      exp_f = (i == 2) || (i == 5);
      checkOutput($sformatf("sim_main_cs_%0d", i), {31'b0, avm_chipselect}, {31'b0, (i == 2)});
      checkOutput($sformatf("sim_fast_cs_%0d", i), {31'b0, cs_f}, {31'b0, exp_f});
      if (i == 2) begin
        checkOutput("sim_main_wd0", avm_writedata, 32'h0000_0A0A);
        checkOutput("sim_fast_wd0", writedata_f, 32'h0000_0A0A);
      end
      if (i == 5) checkOutput("sim_fast_wd1", writedata_f, 32'h0000_0B0B);
    end
    waitWrite(15, wc, wd);
    checkOutput("sim_main_wr1_cycle", wc - t, 32'd12);
    checkOutput("sim_main_wr1_data", wd, 32'h0000_0B0B);

    // ---------------- reset during WRITE ----------------
    doReset();
    applyStimulus(1'b1, 16'h5555, 1'b1, 16'h6666);
    applyStimulus(1'b0, 16'h0, 1'b0, 16'h0);
    applyStimulus(1'b0, 16'h0, 1'b0, 16'h0);
    @(negedge clk);
    checkOutput("rstw_cs_before", {31'b0, avm_chipselect}, 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    checkOutput("rstw_cs_async", {31'b0, avm_chipselect}, 32'd0);
    checkOutput("rstw_wn_async", {31'b0, avm_write_n}, 32'd1);
    checkOutput("rstw_wd_async", avm_writedata, 32'd0);
    checkOutput("rstw_ack_async", {30'b0, ack0, ack1}, 32'd0);
    checkOutput("rstw_ov_async", {31'b0, owner_valid}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    waitWrite(15, wc, wd);
    checkOutput("rstw_no_write", wc, 32'hFFFF_FFFF);
    checkOutput("rstw_ov_after", {31'b0, owner_valid}, 32'd0);

    // ---------------- slot-full hold ----------------
    doReset();
    applyStimulus(1'b1, 16'h1111, 1'b0, 16'h0);
    t = cyc;
    applyStimulus(1'b0, 16'h0, 1'b0, 16'h0);
    applyStimulus(1'b0, 16'h0, 1'b0, 16'h0);
    acks = 0;
    first_w = -1;
    for (int i = 3; i <= 22; i++) begin
      applyStimulus(1'b0, 16'h0, 1'b1, 16'h0C0C);
      @(negedge clk);
      if (avm_chipselect && first_w < 0) first_w = cyc - t;
      if (ack1 && first_w < 0) acks++;
    end
    applyStimulus(1'b0, 16'h0, 1'b0, 16'h0);
    checkOutput("hold_acks_before_write", acks, 32'd1);
    checkOutput("hold_write_cycle", first_w, 32'd12);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 16'h0, 1'b0, 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
